alu_mc: RTL
===========

Name: alu_mc

Overview:
- Parametrised multi-cycle ALU, next generation of the single-cycle datapath ALU.
- Widens the op set from 2-bit to 3-bit control: ADD/SUB/AND/OR/XOR are single-step; MUL/UDIV/UREM are iterative.
- Uses valid/ready handshakes on input and output. Result and NZCV flags are registered.
- Sits between the decode/execute stage and a future multi-cycle control FSM that stalls on in_ready/out_valid.

Parameters:
- WIDTH, 32: operand/result width. Must be ≥ 4.
- BITS_PER_CYCLE, 1: multiply/divide bits retired per iteration. Must divide WIDTH.

Ports:
- clk  in  1  clock, all state on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operands and op are valid
- in_ready  out  1  block can accept an operation
- src_a  in  WIDTH  operand A
- src_b  in  WIDTH  operand B
- alu_control  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 MUL (low WIDTH bits), 110 UDIV, 111 UREM
- out_valid  out  1  result and flags valid
- out_ready  in  1  consumer takes the result
- alu_result  out  WIDTH  registered result
- alu_flags  out  4  {N,Z,C,V}, registered
- div_by_zero  out  1  UDIV/UREM with src_b==0, registered

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, in_ready=1, out_valid=0.
  - alu_result=0, alu_flags=0, div_by_zero=0, iteration counter=0.
  - Reset mid-operation abandons the operation. No output is produced for it.
- FSM states: IDLE, CALC, DONE.
  - in_ready=1 only in IDLE. out_valid=1 only in DONE.
  - Accept = in_valid && in_ready at a rising edge (edge k). Operands and op are latched at edge k.
  - in_valid while not in IDLE is ignored. Upstream must hold it.
- Single-step ops (ADD/SUB/AND/OR/XOR): IDLE→DONE at edge k. out_valid visible in cycle k+1 (latency 1).
- Iterative ops (MUL/UDIV/UREM): IDLE→CALC at edge k.
  - STEPS = WIDTH/BITS_PER_CYCLE iterations, one per edge.
  - CALC→DONE on the edge completing the last iteration, edge k+STEPS. out_valid visible in cycle k+STEPS+1.
- DONE→IDLE on out_ready=1. alu_result, alu_flags and div_by_zero hold stable while out_valid=1 && out_ready=0.
- Arithmetic:
  - ADD: {cout,res} = a+b over WIDTH+1 bits.
  - SUB: computed as a + ~b + 1. C = carry out (ARM convention: C=1 means no borrow).
  - V for ADD: a[MSB]==b[MSB] && res[MSB]!=a[MSB].
  - V for SUB: a[MSB]!=b[MSB] && res[MSB]!=a[MSB].
  - AND/OR/XOR/MUL/UDIV/UREM: C=0, V=0.
  - N = res[WIDTH-1] for all ops. Z = (res==0) for all ops.
  - MUL: unsigned shift-add. Result is the low WIDTH bits of the product, identical for signed operands.
  - UDIV/UREM: restoring divide over STEPS iterations.
- Divide by zero (src_b==0) with UDIV/UREM:
  - Still takes STEPS cycles, so latency is data-independent.
  - UDIV result = all-ones. UREM result = src_a. div_by_zero=1.
  - div_by_zero=0 for every other result.
- Simultaneous events: out_ready in DONE and a new in_valid in the same cycle → return to IDLE only; the new op is accepted the next cycle. Max throughput is 1 op per 2 cycles.

Decomposition:
- Shared package alu_pkg:
  - alu_control encodings (ALU_ADD..ALU_UREM).
  - Flag bit indices (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0).
  - State encoding.
- One sub-module: alu_muldiv_iter.
  - Iterative MUL/UDIV/UREM datapath, counter and BITS_PER_CYCLE loop.
  - start/done interface.
- The top level holds the FSM, the single-step ops, the flag logic and the output registers.

Test Plan (WIDTH=32, BITS_PER_CYCLE=1):
- ADD 0x7FFFFFFF+0x00000001, out_ready=1 → out_valid in cycle after accept, result 0x80000000, flags N=1 Z=0 C=0 V=1.
- SUB 5−5 → 0x00000000, N=0 Z=1 C=1 V=0. SUB 0−1 → 0xFFFFFFFF, N=1 Z=0 C=0 V=0.
- MUL 7×6 → 42 with out_valid exactly 33 cycles after accept. MUL 0x00010000×0x00010000 → 0x00000000, Z=1.
- UDIV 100/7 → 14. UREM 100/7 → 2. UDIV 0x1234/0 → 0xFFFFFFFF with div_by_zero=1. UREM 0x1234/0 → 0x1234 with div_by_zero=1.
- Backpressure: hold out_ready=0 for 5 cycles after an XOR result → result/flags stable, in_ready=0, a pulsed second in_valid is not accepted. out_ready=1 → in_ready=1 the next cycle.
- Assert reset_n=0 at iteration 10 of a MUL → out_valid=0 and outputs zero immediately. After release, in_ready=1; a following ADD 2+3 returns 5 with correct flags.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings for the multi-cycle ALU: op codes, flag bit positions and FSM states.
package alu_pkg;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_SUB  = 3'b001,
        ALU_AND  = 3'b010,
        ALU_OR   = 3'b011,
        ALU_XOR  = 3'b100,
        ALU_MUL  = 3'b101,
        ALU_UDIV = 3'b110,
        ALU_UREM = 3'b111
    } alu_op_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

    function automatic logic is_iterative(input alu_op_e op);
        return (op == ALU_MUL) || (op == ALU_UDIV) || (op == ALU_UREM);
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative shift-add multiplier and restoring divider, BITS_PER_CYCLE bits per step.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  alu_op_e          op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int STEPS = WIDTH / BITS_PER_CYCLE;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    logic             busy;
    logic             is_mul;
    logic             is_rem;
    logic [CW-1:0]    count;
    // acc: product (MUL) or partial remainder (DIV); opx: multiplicand or dividend/quotient;
    // opy: multiplier or divisor.
    logic [WIDTH:0]   acc, acc_nxt;
    logic [WIDTH-1:0] opx, opx_nxt;
    logic [WIDTH-1:0] opy, opy_nxt;

    always_comb begin
        acc_nxt = acc;
        opx_nxt = opx;
        opy_nxt = opy;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (is_mul) begin
                if (opy_nxt[0]) begin
                    acc_nxt = {1'b0, acc_nxt[WIDTH-1:0] + opx_nxt};
                end
                opx_nxt = opx_nxt << 1;
                opy_nxt = opy_nxt >> 1;
            end else begin
                // A zero divisor always "fits", giving an all-ones quotient and remainder == dividend.
                acc_nxt = {acc_nxt[WIDTH-1:0], opx_nxt[WIDTH-1]};
                opx_nxt = opx_nxt << 1;
                if (acc_nxt >= {1'b0, opy_nxt}) begin
                    acc_nxt    = acc_nxt - {1'b0, opy_nxt};
                    opx_nxt[0] = 1'b1;
                end
            end
        end
    end

    assign done   = busy && (count == CW'(STEPS - 1));
    assign result = (is_mul || is_rem) ? acc_nxt[WIDTH-1:0] : opx_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy   <= 1'b0;
            is_mul <= 1'b0;
            is_rem <= 1'b0;
            count  <= '0;
            acc    <= '0;
            opx    <= '0;
            opy    <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            is_mul <= (op == ALU_MUL);
            is_rem <= (op == ALU_UREM);
            count  <= '0;
            acc    <= '0;
            opx    <= a;
            opy    <= b;
        end else if (busy) begin
            acc   <= acc_nxt;
            opx   <= opx_nxt;
            opy   <= opy_nxt;
            count <= done ? '0 : count + 1'b1;
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU top: handshake FSM, single-step ops, flag generation and output registers.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [2:0]       alu_control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_result,
    output logic [3:0]       alu_flags,
    output logic             div_by_zero
);

    alu_state_e       state, state_nxt;
    alu_op_e          op;
    logic             accept;
    logic             op_iter;
    logic             div_q;
    logic             b_zero_q;
    logic             iter_done;
    logic [WIDTH-1:0] iter_result;
    logic [WIDTH-1:0] single_res;
    logic [3:0]       single_flags;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum_ext;

    assign op      = alu_op_e'(alu_control);
    assign op_iter = is_iterative(op);
    assign accept  = in_valid && (state == ST_IDLE);

    alu_muldiv_iter #(
        .WIDTH          (WIDTH),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_muldiv (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (accept && op_iter),
        .op      (op),
        .a       (src_a),
        .b       (src_b),
        .done    (iter_done),
        .result  (iter_result)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (in_valid) state_nxt = op_iter ? ST_CALC : ST_DONE;
            ST_CALC: if (iter_done) state_nxt = ST_DONE;
            ST_DONE: if (out_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == ST_IDLE);
        out_valid = (state == ST_DONE);
    end

    // SUB reuses the adder as a + ~b + 1, so C is the ARM-style "no borrow" carry.
    always_comb begin
        b_eff        = (op == ALU_SUB) ? ~src_b : src_b;
        sum_ext      = {1'b0, src_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, (op == ALU_SUB)};
        single_res   = '0;
        single_flags = '0;
        case (op)
            ALU_ADD, ALU_SUB: begin
                single_res           = sum_ext[WIDTH-1:0];
                single_flags[FLAG_C] = sum_ext[WIDTH];
                single_flags[FLAG_V] = (src_a[WIDTH-1] == b_eff[WIDTH-1]) &&
                                       (sum_ext[WIDTH-1] != src_a[WIDTH-1]);
            end
            ALU_AND: single_res = src_a & src_b;
            ALU_OR:  single_res = src_a | src_b;
            ALU_XOR: single_res = src_a ^ src_b;
            default: single_res = '0;
        endcase
        single_flags[FLAG_N] = single_res[WIDTH-1];
        single_flags[FLAG_Z] = (single_res == '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            alu_result  <= '0;
            alu_flags   <= '0;
            div_by_zero <= 1'b0;
            div_q       <= 1'b0;
            b_zero_q    <= 1'b0;
        end else if (accept && !op_iter) begin
            alu_result  <= single_res;
            alu_flags   <= single_flags;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            div_q    <= (op != ALU_MUL);
            b_zero_q <= (src_b == '0);
        end else if ((state == ST_CALC) && iter_done) begin
            alu_result          <= iter_result;
            alu_flags           <= '0;
            alu_flags[FLAG_N]   <= iter_result[WIDTH-1];
            alu_flags[FLAG_Z]   <= (iter_result == '0);
            div_by_zero         <= div_q && b_zero_q;
        end
    end

endmodule
